// File: rtl/mod_exp.sv
// Sequential modular exponentiation: result = base^exponent mod modulus.
// Left-to-right square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier.
module mod_exp #(
  parameter int WIDTH = 512
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TOP_IDX = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SQR   = 3'd2,
    ST_MUL   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] b_r, e_r, m_r, r_r;
  logic [WIDTH+1:0] p_r;
  logic [CW-1:0]    k_r, i_r;
  logic             err_r;

  logic [WIDTH-1:0] y_s;
  logic [WIDTH+1:0] m_ext_s, p2_s, p3_s, p4_s;
  logic             last_bit_s, illegal_s;

  // One Blakley step: P = 2P (+Y if X[i]), then at most two conditional subtracts of M.
  always_comb begin
    y_s     = (state_r == ST_MUL) ? b_r : r_r;
    m_ext_s = {2'b00, m_r};
    if (r_r[i_r]) begin
      p2_s = (p_r << 1) + {2'b00, y_s};
    end else begin
      p2_s = p_r << 1;
    end
    if (p2_s >= m_ext_s) begin
      p3_s = p2_s - m_ext_s;
    end else begin
      p3_s = p2_s;
    end
    if (p3_s >= m_ext_s) begin
      p4_s = p3_s - m_ext_s;
    end else begin
      p4_s = p3_s;
    end
    last_bit_s = (i_r == {CW{1'b0}});
    illegal_s  = (m_r < WIDTH'(2)) || (b_r >= m_r);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_CHECK;
        else       state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (illegal_s) state_s = ST_FIN;
        else           state_s = ST_SQR;
      end
      ST_SQR: begin
        if (!last_bit_s)             state_s = ST_SQR;
        else if (e_r[k_r])           state_s = ST_MUL;
        else if (k_r == {CW{1'b0}})  state_s = ST_FIN;
        else                         state_s = ST_SQR;
      end
      ST_MUL: begin
        if (!last_bit_s)             state_s = ST_MUL;
        else if (k_r == {CW{1'b0}})  state_s = ST_FIN;
        else                         state_s = ST_SQR;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Operand latches, exponentiation datapath and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_r    <= '0;
      e_r    <= '0;
      m_r    <= '0;
      r_r    <= '0;
      p_r    <= '0;
      k_r    <= '0;
      i_r    <= '0;
      err_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            b_r  <= base;
            e_r  <= exponent;
            m_r  <= modulus;
            busy <= 1'b1;
          end
        end
        ST_CHECK: begin
          err_r <= illegal_s;
          r_r   <= WIDTH'(1);
          p_r   <= '0;
          k_r   <= TOP_IDX;
          i_r   <= TOP_IDX;
        end
        ST_SQR, ST_MUL: begin
          if (last_bit_s) begin
            r_r <= p4_s[WIDTH-1:0];
            p_r <= '0;
            i_r <= TOP_IDX;
            // A set exponent bit after SQR keeps k for the following MUL.
            if (!((state_r == ST_SQR) && e_r[k_r]) && (k_r != {CW{1'b0}})) begin
              k_r <= k_r - {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            p_r <= p4_s;
            i_r <= i_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_FIN: begin
          result <= err_r ? '0 : r_r;
          error  <= err_r;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
